move_sort_sequencer: RTL and testbench

Sequencer that sorts the move-list RAM in place after move generation fills it. It owns both local ports of the dual-port move RAM while sorting and runs an early-exit bubble sort over `entry_count` entries. Illegal positions, where the side that just moved is in check, sink to the end; the rest are ordered best-first for the side to move. It sits between the move generator / host loader (external I/O) and the RAM, and drives the external-I/O mux select.

---
 rtl/move_sort_sequencer_pkg.sv | 22 ++
 rtl/move_sort_sequencer_if.sv | 25 ++
 rtl/move_sort_sequencer_cmp.sv | 34 +++
 rtl/move_sort_sequencer.sv | 174 +++++++++++++++++
 tb/tb_move_sort_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/move_sort_sequencer_pkg.sv
// Shared constants, FSM state encoding and helpers for the move-list sort sequencer.
// Check-flag bits sit directly above the signed eval field of each RAM entry.
package move_sort_sequencer_pkg;

  localparam int MAX_POSITIONS   = 16;
  localparam int BLACK_CHECK_OFS = 0;
  localparam int WHITE_CHECK_OFS = 1;
  localparam int STAT_WIDTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_CMP      = 3'd2,
    ST_WR       = 3'd3,
    ST_PASS_END = 3'd4
  } sort_state_t;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/move_sort_sequencer_if.sv
// Local dual-port move RAM bundle: shared read/write address per port, 1-cycle read latency.
// master = sort sequencer side, slave = RAM side.
interface move_sort_sequencer_if #(
  parameter int RAM_WIDTH  = 1,
  parameter int ADDR_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  a_wr;
  logic                  b_wr;
  logic [RAM_WIDTH-1:0]  a_wr_data;
  logic [RAM_WIDTH-1:0]  b_wr_data;
  logic [RAM_WIDTH-1:0]  a_rd_data;
  logic [RAM_WIDTH-1:0]  b_rd_data;

  modport master (
    output a_addr, b_addr, a_wr, b_wr, a_wr_data, b_wr_data,
    input  a_rd_data, b_rd_data
  );

  modport slave (
    input  a_addr, b_addr, a_wr, b_wr, a_wr_data, b_wr_data,
    output a_rd_data, b_rd_data
  );
endinterface

// File: rtl/move_sort_sequencer_cmp.sv
// move_sort_cmp: combinational key order; b_better is high only when B strictly outranks A.
// Legal beats illegal, legal entries ordered by signed eval for the side to move, ties never swap.
module move_sort_cmp
  import move_sort_sequencer_pkg::*;
#(
  parameter int RAM_WIDTH  = 0,
  parameter int EVAL_WIDTH = 0
) (
  input  logic [RAM_WIDTH-1:0] a_entry,
  input  logic [RAM_WIDTH-1:0] b_entry,
  input  logic                 white_to_move,
  output logic                 b_better
);
  logic                         a_illegal;
  logic                         b_illegal;
  logic signed [EVAL_WIDTH-1:0] a_eval;
  logic signed [EVAL_WIDTH-1:0] b_eval;
  logic                         unused_hi;

  assign unused_hi = ^{a_entry[RAM_WIDTH-1:EVAL_WIDTH+2], b_entry[RAM_WIDTH-1:EVAL_WIDTH+2]};

  always_comb begin
    a_illegal = white_to_move ? a_entry[EVAL_WIDTH+WHITE_CHECK_OFS] : a_entry[EVAL_WIDTH+BLACK_CHECK_OFS];
    b_illegal = white_to_move ? b_entry[EVAL_WIDTH+WHITE_CHECK_OFS] : b_entry[EVAL_WIDTH+BLACK_CHECK_OFS];
    a_eval    = a_entry[EVAL_WIDTH-1:0];
    b_eval    = b_entry[EVAL_WIDTH-1:0];
    b_better  = 1'b0;
    if (a_illegal != b_illegal) begin
      b_better = a_illegal;
    end else if (!a_illegal) begin
      b_better = white_to_move ? (b_eval > a_eval) : (b_eval < a_eval);
    end
  end
endmodule

// File: rtl/move_sort_sequencer.sv
// In-place early-exit bubble sort of the move RAM; sort_complete rises 2C+S+P+1 cycles after start.
// No backpressure: RAM is owned for the whole sort; abort returns to IDLE. MOVE_SORT_STATS_EN adds counters.
module move_sort_sequencer
  import move_sort_sequencer_pkg::*;
#(
  parameter int RAM_WIDTH          = 0,
  parameter int EVAL_WIDTH         = 0,
  parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sort_start,
  input  logic                          sort_abort,
  input  logic                          white_to_move,
  input  logic [MAX_POSITIONS_LOG2:0]   entry_count,
  move_sort_sequencer_if.master         ram,
  output logic                          ram_owned,
  output logic                          sort_complete,
  output logic [STAT_WIDTH-1:0]         compare_count,
  output logic [STAT_WIDTH-1:0]         swap_count
);
  localparam int AW = MAX_POSITIONS_LOG2;

  sort_state_t   state;
  logic          wtm_q;
  logic          swapped_q;
  logic          done_pend_q;
  logic [AW-1:0] i_q;
  logic [AW-1:0] last_q;
  logic [AW-1:0] next_i;
  logic          b_better;

  assign next_i = i_q + AW'(1);

  move_sort_cmp #(
    .RAM_WIDTH  (RAM_WIDTH),
    .EVAL_WIDTH (EVAL_WIDTH)
  ) u_cmp (
    .a_entry       (ram.a_rd_data),
    .b_entry       (ram.b_rd_data),
    .white_to_move (wtm_q),
    .b_better      (b_better)
  );

  // done_pend_q holds one IDLE cycle before sort_complete/ram_owned flip together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      wtm_q         <= 1'b0;
      swapped_q     <= 1'b0;
      done_pend_q   <= 1'b0;
      i_q           <= '0;
      last_q        <= '0;
      ram.a_addr    <= '0;
      ram.b_addr    <= '0;
      ram.a_wr      <= 1'b0;
      ram.b_wr      <= 1'b0;
      ram.a_wr_data <= '0;
      ram.b_wr_data <= '0;
      ram_owned     <= 1'b0;
      sort_complete <= 1'b1;
    end else begin
      ram.a_wr <= 1'b0;
      ram.b_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (done_pend_q) begin
            done_pend_q   <= 1'b0;
            sort_complete <= 1'b1;
            ram_owned     <= 1'b0;
          end else if (sort_start) begin
            wtm_q         <= white_to_move;
            sort_complete <= 1'b0;
            ram_owned     <= 1'b1;
            if (entry_count < (AW+1)'(2)) begin
              done_pend_q <= 1'b1;
            end else begin
              i_q        <= '0;
              last_q     <= AW'(entry_count - 1'b1);
              swapped_q  <= 1'b0;
              ram.a_addr <= '0;
              ram.b_addr <= AW'(1);
              state      <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (sort_abort) begin
            state         <= ST_IDLE;
            sort_complete <= 1'b1;
            ram_owned     <= 1'b0;
          end else begin
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (sort_abort) begin
            state         <= ST_IDLE;
            sort_complete <= 1'b1;
            ram_owned     <= 1'b0;
          end else if (b_better) begin
            ram.a_wr      <= 1'b1;
            ram.b_wr      <= 1'b1;
            ram.a_wr_data <= ram.b_rd_data;
            ram.b_wr_data <= ram.a_rd_data;
            state         <= ST_WR;
          end else begin
            i_q        <= next_i;
            ram.a_addr <= next_i;
            ram.b_addr <= next_i + AW'(1);
            state      <= (next_i < last_q) ? ST_RD : ST_PASS_END;
          end
        end
        ST_WR: begin
          // The swap write commits at this edge regardless of abort, keeping the RAM a permutation.
          swapped_q <= 1'b1;
          if (sort_abort) begin
            state         <= ST_IDLE;
            sort_complete <= 1'b1;
            ram_owned     <= 1'b0;
          end else begin
            i_q        <= next_i;
            ram.a_addr <= next_i;
            ram.b_addr <= next_i + AW'(1);
            state      <= (next_i < last_q) ? ST_RD : ST_PASS_END;
          end
        end
        ST_PASS_END: begin
          if (sort_abort) begin
            state         <= ST_IDLE;
            sort_complete <= 1'b1;
            ram_owned     <= 1'b0;
          end else if (!swapped_q || last_q == AW'(1)) begin
            state       <= ST_IDLE;
            done_pend_q <= 1'b1;
          end else begin
            last_q     <= last_q - AW'(1);
            i_q        <= '0;
            swapped_q  <= 1'b0;
            ram.a_addr <= '0;
            ram.b_addr <= AW'(1);
            state      <= ST_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MOVE_SORT_STATS_EN
  logic [STAT_WIDTH-1:0] cmp_cnt_q;
  logic [STAT_WIDTH-1:0] swp_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_cnt_q <= '0;
      swp_cnt_q <= '0;
    end else if (state == ST_IDLE && !done_pend_q && sort_start) begin
      cmp_cnt_q <= '0;
      swp_cnt_q <= '0;
    end else begin
      if (state == ST_CMP && !sort_abort) cmp_cnt_q <= sat_inc(cmp_cnt_q);
      if (state == ST_WR)                 swp_cnt_q <= sat_inc(swp_cnt_q);
    end
  end

  assign compare_count = cmp_cnt_q;
  assign swap_count    = swp_cnt_q;
`else
  assign compare_count = '0;
  assign swap_count    = '0;
`endif

endmodule

// File: tb/tb_move_sort_sequencer.sv
// Self-checking bench for move_sort_sequencer: directed cases, randomized sorts, abort and reset.
// Reference model sorts an array by the key rules and derives compare/swap/pass counts.
module tb_move_sort_sequencer;
  localparam int RW   = 24;
  localparam int EW   = 16;
  localparam int AW   = 4;
  localparam int NMAX = 16;
`ifdef MOVE_SORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sort_start = 1'b0;
  logic          sort_abort = 1'b0;
  logic          white_to_move = 1'b0;
  logic [AW:0]   entry_count = '0;
  logic          ram_owned;
  logic          sort_complete;
  logic [15:0]   compare_count;
  logic [15:0]   swap_count;

  logic [RW-1:0] mem [NMAX];
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [RW-1:0] ld_data = '0;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int viol = 0;
  int last_lat = 0;
  logic [RW-1:0] stim [NMAX];
  logic [RW-1:0] expv [NMAX];
  int exp_c, exp_s, exp_p;

  move_sort_sequencer_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) ram_if ();

  move_sort_sequencer #(
    .RAM_WIDTH          (RW),
    .EVAL_WIDTH         (EW),
    .MAX_POSITIONS_LOG2 (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sort_start    (sort_start),
    .sort_abort    (sort_abort),
    .white_to_move (white_to_move),
    .entry_count   (entry_count),
    .ram           (ram_if),
    .ram_owned     (ram_owned),
    .sort_complete (sort_complete),
    .compare_count (compare_count),
    .swap_count    (swap_count)
  );

  always #5 clk = ~clk;

  // RAM with external-I/O mux: local ports while owned, loader otherwise.
  always @(posedge clk) begin
    if (ram_owned) begin
      if (ram_if.a_wr) mem[ram_if.a_addr] <= ram_if.a_wr_data;
      if (ram_if.b_wr) mem[ram_if.b_addr] <= ram_if.b_wr_data;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
    ram_if.a_rd_data <= mem[ram_if.a_addr];
    ram_if.b_rd_data <= mem[ram_if.b_addr];
  end

  always @(posedge clk) begin
    if (ram_if.a_wr === 1'b1) wr_cycles++;
    if (((ram_if.a_wr || ram_if.b_wr) && !ram_owned) || (ram_if.a_wr !== ram_if.b_wr)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int tag, input bit wic, input bit bic, input int ev);
    return {tag[5:0], wic, bic, ev[15:0]};
  endfunction

  function automatic bit better(input logic [RW-1:0] a, input logic [RW-1:0] b, input bit wtm);
    bit ia, ib;
    int ea, eb;
    ia = wtm ? a[EW+1] : a[EW];
    ib = wtm ? b[EW+1] : b[EW];
    ea = int'($signed(a[EW-1:0]));
    eb = int'($signed(b[EW-1:0]));
    if (ia != ib) return ia;
    if (ia) return 1'b0;
    return wtm ? (eb > ea) : (eb < ea);
  endfunction

  task automatic model(input bit wtm, input int n);
    int last;
    bit sw;
    logic [RW-1:0] t;
    for (int k = 0; k < NMAX; k++) expv[k] = stim[k];
    exp_c = 0; exp_s = 0; exp_p = 0;
    if (n < 2) return;
    last = n - 1;
    forever begin
      exp_p++;
      sw = 1'b0;
      for (int i = 0; i < last; i++) begin
        exp_c++;
        if (better(expv[i], expv[i+1], wtm)) begin
          t = expv[i]; expv[i] = expv[i+1]; expv[i+1] = t;
          exp_s++;
          sw = 1'b1;
        end
      end
      if (!sw || last == 1) break;
      last--;
    end
  endtask

  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = AW'(k); ld_data = stim[k];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_sort(input string tag, input bit wtm, input int n);
    int cycles, w0, v0, exp_lat;
    bit prev_owned;
    load(n);
    model(wtm, n);
    w0 = wr_cycles; v0 = viol;
    sort_start = 1'b1; white_to_move = wtm; entry_count = (AW+1)'(n);
    @(posedge clk); #1;
    sort_start = 1'b0;
    check({tag, "_busy"}, 32'(sort_complete), 0);
    check({tag, "_owned"}, 32'(ram_owned), 1);
    cycles = 0;
    prev_owned = ram_owned;
    while (sort_complete !== 1'b1 && cycles < 4000) begin
      prev_owned = ram_owned;
      @(posedge clk); #1;
      cycles++;
    end
    exp_lat = (n < 2) ? 1 : 2*exp_c + exp_s + 1 + exp_p;
    last_lat = cycles;
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_owned_drop"}, 32'(ram_owned), 0);
    check({tag, "_owned_before"}, 32'(prev_owned), 1);
    for (int k = 0; k < n; k++) check($sformatf("%s_ram%0d", tag, k), 32'(mem[k]), 32'(expv[k]));
    check({tag, "_cmp_cnt"}, 32'(compare_count), STATS ? exp_c : 0);
    check({tag, "_swp_cnt"}, 32'(swap_count), STATS ? exp_s : 0);
    check({tag, "_writes"}, wr_cycles - w0, exp_s);
    check({tag, "_wr_viol"}, viol - v0, 0);
  endtask

  initial begin
    int n, cyc, w0;
    bit wtm;

    repeat (3) @(posedge clk);
    #1;
    check("rst_complete", 32'(sort_complete), 1);
    check("rst_owned", 32'(ram_owned), 0);
    check("rst_a_wr", 32'(ram_if.a_wr), 0);
    check("rst_b_wr", 32'(ram_if.b_wr), 0);
    check("rst_a_addr", 32'(ram_if.a_addr), 0);
    check("rst_b_addr", 32'(ram_if.b_addr), 0);
    check("rst_wr_data", 32'(ram_if.a_wr_data | ram_if.b_wr_data), 0);
    check("rst_counts", 32'(compare_count | swap_count), 0);
    @(negedge clk);
    reset = 1'b1;

    stim[0] = mk(0, 0, 0, 10); stim[1] = mk(1, 0, 0, 30); stim[2] = mk(2, 0, 0, 20);
    run_sort("tp1", 1'b1, 3);
    check("tp1_lat11", last_lat, 11);
    check("tp1_head", 32'(mem[0]), 32'(mk(1, 0, 0, 30)));

    stim[0] = mk(0, 0, 0, 5); stim[1] = mk(1, 0, 0, -7); stim[2] = mk(2, 0, 0, 5); stim[3] = mk(3, 0, 0, 0);
    run_sort("tp2", 1'b0, 4);
    check("tp2_head", 32'(mem[0]), 32'(mk(1, 0, 0, -7)));
    check("tp2_stable_a", 32'(mem[2][RW-1:EW+2]), 0);
    check("tp2_stable_b", 32'(mem[3][RW-1:EW+2]), 2);

    stim[0] = mk(0, 1, 0, 100); stim[1] = mk(1, 0, 0, 50); stim[2] = mk(2, 0, 0, 60);
    run_sort("tp3", 1'b1, 3);
    check("tp3_illegal_last", 32'(mem[2]), 32'(mk(0, 1, 0, 100)));

    run_sort("n0", 1'b1, 0);
    stim[0] = mk(5, 0, 0, 3);
    run_sort("n1", 1'b0, 1);

    // Abort while the swap write is in flight.
    stim[0] = mk(0, 0, 0, 1); stim[1] = mk(1, 0, 0, 2);
    load(2);
    sort_start = 1'b1; white_to_move = 1'b1; entry_count = 2;
    @(posedge clk); #1;
    sort_start = 1'b0;
    cyc = 0;
    while (ram_if.a_wr !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("abort_reached_wr", 32'(ram_if.a_wr), 1);
    w0 = wr_cycles;
    sort_abort = 1'b1;
    @(posedge clk); #1;
    sort_abort = 1'b0;
    check("abort_owned", 32'(ram_owned), 0);
    check("abort_complete", 32'(sort_complete), 1);
    check("abort_a_wr", 32'(ram_if.a_wr), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_writes", wr_cycles - w0, 1);
    check("abort_ram0", 32'(mem[0]), 32'(mk(1, 0, 0, 2)));
    check("abort_ram1", 32'(mem[1]), 32'(mk(0, 0, 0, 1)));

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, NMAX);
      wtm = 1'($urandom_range(0, 1));
      for (int k = 0; k < NMAX; k++)
        stim[k] = mk(k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 40)) - 20);
      run_sort($sformatf("rnd%0d", r), wtm, n);
    end

    // Reset pulsed in the middle of a sort.
    for (int k = 0; k < NMAX; k++) stim[k] = mk(k, 0, 0, k);
    load(10);
    sort_start = 1'b1; white_to_move = 1'b1; entry_count = 10;
    @(posedge clk); #1;
    sort_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_complete", 32'(sort_complete), 1);
    check("midrst_owned", 32'(ram_owned), 0);
    check("midrst_wr", 32'(ram_if.a_wr | ram_if.b_wr), 0);
    check("midrst_addr", 32'(ram_if.a_addr | ram_if.b_addr), 0);
    check("midrst_counts", 32'(compare_count | swap_count), 0);
    @(negedge clk);
    reset = 1'b1;
    stim[0] = mk(0, 0, 0, 1); stim[1] = mk(1, 0, 0, 2);
    run_sort("post_rst", 1'b1, 2);
    check("post_rst_head", 32'(mem[0]), 32'(mk(1, 0, 0, 2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
